pong_game_ctrl: RTL
===================

// Module: pong_game_ctrl
// PURPOSE
//  Top-level Pong game sequencer. Gates ball motion per frame, holds the ball at
//  centre during serve, tallies points from the ball block's scored pulses, and
//  declares a winner. Sits between the keyboard decoder and the ball/paddle
//  blocks; drives the score display.
// PARAMETERS
//  START_KEY     103  key byte that starts/serves a game ('g')
//  RESTART_KEY   98   key byte that aborts to IDLE ('b')
//  PAUSE_KEY     112  key byte toggling pause ('p'); used only with PONG_PAUSE_EN
//  WIN_SCORE     7    points needed to win (1..2^SCORE_W-1)
//  SERVE_FRAMES  60   frame ticks the ball is held at centre before play
//  SCORE_W       4    score counter width
// PORTS
//  i_CLK          in   1        system clock
//  i_RST_N        in   1        reset, synchronous, active-low
//  i_frame_tick   in   1        1-cycle pulse per video frame
//  i_key_byte     in   8        decoded key byte
//  i_key_valid    in   1        i_key_byte valid this cycle (1-cycle pulse)
//  i_p1_scored    in   1        pulse: player 1 won the point
//  i_p2_scored    in   1        pulse: player 2 won the point
//  o_ball_en      out  1        1-cycle ball-move strobe
//  o_ball_center  out  1        level: ball held at start position
//  o_p1_score     out  SCORE_W  player 1 score
//  o_p2_score     out  SCORE_W  player 2 score
//  o_state        out  3        current state encoding
//  o_winner       out  2        00 none, 01 P1, 10 P2
// BEHAVIOUR
//  One clock; reset is synchronous and active-low. All outputs registered.
//  Reset: state IDLE, scores 0, o_winner 00, o_ball_en 0, o_ball_center 1, serve cnt 0.
//  Keys sampled only when i_key_valid=1. RESTART from any state -> IDLE next cycle,
//   scores and winner cleared; RESTART beats every other event in the same cycle.
//  States (o_state): IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4, PAUSE=5.
//  IDLE: START -> SERVE, load serve cnt = SERVE_FRAMES.
//  SERVE: cnt decrements on i_frame_tick; tick seen with cnt==1 (or cnt==0 on entry)
//   -> PLAY. Counter width $clog2(SERVE_FRAMES+1); never wraps below 0.
//  PLAY: o_ball_en = i_frame_tick delayed 1 cycle (only ticks arriving in PLAY);
//   o_ball_center=0. i_p1_scored -> p1 score+1, -> POINT; else i_p2_scored -> p2+1,
//   -> POINT. Both in same cycle: P1 only, P2 dropped. Scored pulses ignored outside PLAY.
//  POINT (1 cycle): score==WIN_SCORE -> OVER, o_winner set; else SERVE, reload cnt.
//  OVER: ball held centre, scores frozen; START -> scores/winner cleared, SERVE.
//  o_ball_center=1 in IDLE, SERVE, POINT, OVER; 0 in PLAY, PAUSE.
//  Score counters saturate at 2^SCORE_W-1 (unreachable when WIN_SCORE legal).
//  Reset asserted mid-game overrides all inputs; i_frame_tick during reset is dropped.
// CONFIGURATION
//  PONG_PAUSE_EN defined: PAUSE_KEY in PLAY -> PAUSE (ball frozen, o_ball_en=0,
//   position kept, scored pulses ignored); PAUSE_KEY in PAUSE -> PLAY; START ignored
//   in PAUSE. Not defined: PAUSE_KEY ignored, state 5 unreachable, no pause logic.
// TESTING
//  1 Reset, key 103 valid, SERVE_FRAMES=3 -> SERVE, 3 ticks later PLAY, o_ball_center 1->0.
//  2 In PLAY, 5 frame ticks -> exactly 5 o_ball_en pulses, each 1 cycle after its tick.
//  3 p1/p2 scored together in PLAY -> p1 score 1, p2 score 0, POINT then SERVE.
//  4 Drive P2 to 7 points -> OVER, o_winner=10; further scored pulses leave scores 7/x.
//  5 Key 98 mid-SERVE with score 3-2 -> IDLE next cycle, scores 0-0, o_winner 00.
//  6 PONG_PAUSE_EN: key 112 in PLAY -> state 5, ticks give no o_ball_en; 112 -> PLAY.

Source files
------------

// File: rtl/pong_game_ctrl.sv
// -----------------------------------------------------------------------------
// pong_game_ctrl
//   Top-level Pong game sequencer. It gates ball motion once per video frame,
//   holds the ball at centre while serving, tallies points from the ball
//   block's scored pulses and declares a winner.
//
//   Optional feature macro: PONG_PAUSE_EN
//     When defined, PAUSE_KEY toggles between PLAY and PAUSE. While paused the
//     ball is frozen and scored pulses are ignored. When undefined there is no
//     pause logic and state 5 is unreachable.
//
// Ports
//   i_CLK          in   1        system clock
//   i_RST_N        in   1        synchronous active-low reset
//   i_frame_tick   in   1        1-cycle pulse per video frame
//   i_key_byte     in   8        decoded key byte
//   i_key_valid    in   1        i_key_byte valid this cycle
//   i_p1_scored    in   1        pulse: player 1 won the point
//   i_p2_scored    in   1        pulse: player 2 won the point
//   o_ball_en      out  1        1-cycle ball-move strobe
//   o_ball_center  out  1        level: ball held at start position
//   o_p1_score     out  SCORE_W  player 1 score
//   o_p2_score     out  SCORE_W  player 2 score
//   o_state        out  3        state (IDLE 0, SERVE 1, PLAY 2, POINT 3,
//                                OVER 4, PAUSE 5)
//   o_winner       out  2        00 none, 01 P1, 10 P2
//
// Handshake: all inputs are single-cycle strobes qualified by their own level
//   (keys only when i_key_valid=1); there is no back-pressure. All outputs are
//   registered and o_state is the state register itself.
// -----------------------------------------------------------------------------
module pong_game_ctrl #(
  parameter int START_KEY    = 103,
  parameter int RESTART_KEY  = 98,
  parameter int PAUSE_KEY    = 112,
  parameter int WIN_SCORE    = 7,
  parameter int SERVE_FRAMES = 60,
  parameter int SCORE_W      = 4
) (
  input  logic               i_CLK,
  input  logic               i_RST_N,
  input  logic               i_frame_tick,
  input  logic [7:0]         i_key_byte,
  input  logic               i_key_valid,
  input  logic               i_p1_scored,
  input  logic               i_p2_scored,
  output logic               o_ball_en,
  output logic               o_ball_center,
  output logic [SCORE_W-1:0] o_p1_score,
  output logic [SCORE_W-1:0] o_p2_score,
  output logic [2:0]         o_state,
  output logic [1:0]         o_winner
);

  // A zero-frame serve still needs a 1-bit counter to exist.
  localparam int CNT_W = (SERVE_FRAMES > 0) ? $clog2(SERVE_FRAMES + 1) : 1;
  localparam logic [CNT_W-1:0]   SERVE_LOAD = CNT_W'(SERVE_FRAMES);
  localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    POINT = 3'd3,
    OVER  = 3'd4,
    PAUSE = 3'd5
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] serve_cnt;

  logic start_hit;
  logic restart_hit;

  assign start_hit   = i_key_valid && (i_key_byte == 8'(START_KEY));
  assign restart_hit = i_key_valid && (i_key_byte == 8'(RESTART_KEY));
  assign o_state     = state;

`ifdef PONG_PAUSE_EN
  logic pause_hit;
  assign pause_hit = i_key_valid && (i_key_byte == 8'(PAUSE_KEY));
`endif

  // Scores hold at all-ones rather than wrapping to zero.
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return (v == '1) ? v : v + SCORE_W'(1);
  endfunction

  always_ff @(posedge i_CLK) begin
    if (!i_RST_N) begin
      state         <= IDLE;
      serve_cnt     <= '0;
      o_p1_score    <= '0;
      o_p2_score    <= '0;
      o_winner      <= 2'b00;
      o_ball_en     <= 1'b0;
      o_ball_center <= 1'b1;
    end else begin
      o_ball_en <= 1'b0;
      if (restart_hit) begin
        // Restart outranks every other event arriving in the same cycle.
        state         <= IDLE;
        serve_cnt     <= '0;
        o_p1_score    <= '0;
        o_p2_score    <= '0;
        o_winner      <= 2'b00;
        o_ball_center <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (start_hit) begin
              state     <= SERVE;
              serve_cnt <= SERVE_LOAD;
            end
          end

          SERVE: begin
            if (i_frame_tick) begin
              // cnt==0 only happens when SERVE_FRAMES is 0.
              if (serve_cnt <= CNT_W'(1)) begin
                state         <= PLAY;
                serve_cnt     <= '0;
                o_ball_center <= 1'b0;
              end else begin
                serve_cnt <= serve_cnt - CNT_W'(1);
              end
            end
          end

          PLAY: begin
`ifdef PONG_PAUSE_EN
            if (pause_hit) begin
              state <= PAUSE;
            end else
`endif
            begin
              o_ball_en <= i_frame_tick;
              // P1 has priority when both pulses coincide; P2's is dropped.
              if (i_p1_scored) begin
                o_p1_score    <= sat_inc(o_p1_score);
                state         <= POINT;
                o_ball_center <= 1'b1;
              end else if (i_p2_scored) begin
                o_p2_score    <= sat_inc(o_p2_score);
                state         <= POINT;
                o_ball_center <= 1'b1;
              end
            end
          end

          POINT: begin
            if (o_p1_score == WIN_VAL) begin
              state    <= OVER;
              o_winner <= 2'b01;
            end else if (o_p2_score == WIN_VAL) begin
              state    <= OVER;
              o_winner <= 2'b10;
            end else begin
              state     <= SERVE;
              serve_cnt <= SERVE_LOAD;
            end
          end

          OVER: begin
            if (start_hit) begin
              state      <= SERVE;
              serve_cnt  <= SERVE_LOAD;
              o_p1_score <= '0;
              o_p2_score <= '0;
              o_winner   <= 2'b00;
            end
          end

`ifdef PONG_PAUSE_EN
          PAUSE: begin
            if (pause_hit) begin
              state <= PLAY;
            end
          end
`endif

          default: begin
            // Unreachable encodings fall back to a safe idle.
            state         <= IDLE;
            o_ball_center <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
